// File: rtl/param_datapath.sv
// Parameterised datapath: register file, A/B operand registers, B shifter, ALU,
// and a multi-cycle shift-add multiplier that writes C and status when it finishes.
module param_datapath #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int PCW   = 9,
    localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    readnum,
    input  logic [RW-1:0]    writenum,
    input  logic             write,
    input  logic [1:0]       vsel,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [PCW-1:0]   PC,
    input  logic             csel,
    input  logic             loada,
    input  logic             loadb,
    input  logic             loadc,
    input  logic             loads,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       shift,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       status,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regFile_q [NREG];
    logic [WIDTH-1:0] aReg_q, bReg_q, cReg_q;
    logic [2:0]       status_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]    count_q;
    logic             loadsCap_q, done_q;

    logic [WIDTH-1:0] readData, wbData, loadVal, shiftedB;
    logic [WIDTH-1:0] aluA, aluB, aluResult, accNext;
    logic             aluOvf, isMulOp, lastStep;

    // Out-of-range indices read as zero so non-power-of-two NREG stays well defined.
    always_comb begin
        readData = '0;
        if (32'(readnum) < 32'(NREG)) readData = regFile_q[readnum];
    end

    always_comb begin
        case (vsel)
            2'b00:   wbData = cReg_q;
            2'b01:   wbData = WIDTH'(PC);
            2'b10:   wbData = sximm8;
            default: wbData = mdata;
        endcase
        loadVal = csel ? wbData : readData;
        case (shift)
            2'b00:   shiftedB = bReg_q;
            2'b01:   shiftedB = {bReg_q[WIDTH-2:0], 1'b0};
            2'b10:   shiftedB = {1'b0, bReg_q[WIDTH-1:1]};
            default: shiftedB = {bReg_q[WIDTH-1], bReg_q[WIDTH-1:1]};
        endcase
        aluA = asel ? '0 : aReg_q;
        aluB = bsel ? sximm5 : shiftedB;
    end

    always_comb begin
        aluResult = '0;
        aluOvf    = 1'b0;
        case (ALUop)
            3'b000, 3'b111: begin
                aluResult = aluA + aluB;
                aluOvf    = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (aluResult[WIDTH-1] != aluA[WIDTH-1]);
            end
            3'b001: begin
                aluResult = aluA - aluB;
                aluOvf    = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (aluResult[WIDTH-1] != aluA[WIDTH-1]);
            end
            3'b010:  aluResult = aluA & aluB;
            3'b011:  aluResult = ~aluB;
            3'b100:  aluResult = aluA | aluB;
            3'b101:  aluResult = aluA ^ aluB;
            default: aluResult = '0;
        endcase
    end

    assign isMulOp  = (ALUop == 3'b110);
    assign accNext  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign lastStep = (state_q == S_MUL) && (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (loadc && isMulOp) state_d = S_MUL;
            S_MUL:  if (lastStep) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regFile_q[i] <= '0;
        end else if (write && (32'(writenum) < 32'(NREG))) begin
            regFile_q[writenum] <= wbData;
        end
    end

    // Operand loads run regardless of state; C and status only move in IDLE or on the last multiply step.
    always_ff @(posedge clk) begin
        if (reset) begin
            aReg_q     <= '0;
            bReg_q     <= '0;
            cReg_q     <= '0;
            status_q   <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            loadsCap_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (loada) aReg_q <= loadVal;
            if (loadb) bReg_q <= loadVal;
            if (state_q == S_IDLE) begin
                if (loadc && isMulOp) begin
                    mcand_q    <= aluA;
                    mplier_q   <= aluB;
                    acc_q      <= '0;
                    count_q    <= '0;
                    loadsCap_q <= loads;
                end else begin
                    if (loadc) cReg_q <= aluResult;
                    if (loads && !isMulOp) status_q <= {aluOvf, aluResult[WIDTH-1], aluResult == '0};
                end
            end else begin
                acc_q    <= accNext;
                mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                count_q  <= count_q + CW'(1);
                if (lastStep) begin
                    cReg_q <= accNext;
                    if (loadsCap_q) status_q <= {1'b0, accNext[WIDTH-1], accNext == '0};
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign C      = cReg_q;
    assign status = status_q;
    assign busy   = (state_q == S_MUL);
    assign done   = done_q;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath: a driver predicts C/status updates from an
// arithmetic model and queues them; a negedge monitor pops and compares.
module tb_param_datapath;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int PCW   = 9;
    localparam int RW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [RW-1:0]    readnum, writenum;
    logic             write;
    logic [1:0]       vsel;
    logic [WIDTH-1:0] mdata, sximm8, sximm5;
    logic [PCW-1:0]   PC;
    logic             csel, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]       shift;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] C;
    logic [2:0]       status;
    logic             busy, done;

    param_datapath #(.WIDTH(WIDTH), .NREG(NREG), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .PC(PC),
        .csel(csel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .C(C), .status(status), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         isMul;
        logic [15:0] c;
        logic [2:0]  st;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          expBusy = 1'b0;
    bit          expDone = 1'b0;
    logic [15:0] shadowC = '0;
    logic [2:0]  shadowSt = '0;

    int          mRegs[NREG];
    int          mA = 0, mB = 0, mC = 0;
    logic [2:0]  mStatus = '0;
    bit          mBusy = 1'b0;
    int          mulEnd = 0;
    int          mulProd = 0;
    bit          mulLoads = 1'b0;

    task automatic checkOutput(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int toSigned(int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic int shiftB(int b, logic [1:0] sh);
        int sb, r;
        case (sh)
            2'd0: return b;
            2'd1: return (b * 2) % 65536;
            2'd2: return b / 2;
            default: begin
                sb = toSigned(b);
                r  = (sb >= 0) ? sb / 2 : -((-sb + 1) / 2);
                return (r + 65536) % 65536;
            end
        endcase
    endfunction

    // Predict the effect of the current inputs at the next edge, then advance one cycle.
    task automatic applyStimulus();
        int   rd, wbv, loadv, ain, bin, res, sr;
        bit   v, completed;
        exp_t e;
        rd = (int'(readnum) < NREG) ? mRegs[readnum] : 0;
        case (vsel)
            2'd0:    wbv = mC;
            2'd1:    wbv = int'(PC);
            2'd2:    wbv = int'(sximm8);
            default: wbv = int'(mdata);
        endcase
        loadv = csel ? wbv : rd;
        ain   = asel ? 0 : mA;
        bin   = bsel ? int'(sximm5) : shiftB(mB, shift);
        v     = 1'b0;
        case (ALUop)
            3'd0, 3'd7: begin
                res = (ain + bin) % 65536;
                sr  = toSigned(ain) + toSigned(bin);
                v   = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                res = (ain - bin + 65536) % 65536;
                sr  = toSigned(ain) - toSigned(bin);
                v   = (sr > 32767) || (sr < -32768);
            end
            3'd2:    res = ain & bin;
            3'd3:    res = 65535 - bin;
            3'd4:    res = ain | bin;
            3'd5:    res = ain ^ bin;
            default: res = 0;
        endcase
        @(posedge clk);
        cyc++;
        completed = 1'b0;
        if (reset) begin
            foreach (mRegs[i]) mRegs[i] = 0;
            mA = 0; mB = 0; mC = 0; mStatus = '0; mBusy = 1'b0;
            expQ.delete();
            e = '{due: cyc, isMul: 1'b0, c: 16'h0, st: 3'b000};
            expQ.push_back(e);
        end else begin
            if (write && int'(writenum) < NREG) mRegs[writenum] = wbv;
            if (loada) mA = loadv;
            if (loadb) mB = loadv;
            if (mBusy) begin
                if (cyc == mulEnd) begin
                    mC = mulProd;
                    if (mulLoads) mStatus = {1'b0, mulProd >= 32768, mulProd == 0};
                    mBusy = 1'b0;
                    completed = 1'b1;
                end
            end else if (loadc && ALUop == 3'd6) begin
                mBusy    = 1'b1;
                mulEnd   = cyc + WIDTH;
                mulProd  = int'((longint'(ain) * longint'(bin)) % 65536);
                mulLoads = loads;
                e = '{due: mulEnd, isMul: 1'b1, c: 16'(mulProd),
                      st: loads ? {1'b0, mulProd >= 32768, mulProd == 0} : mStatus};
                expQ.push_back(e);
            end else begin
                if (loadc) mC = res;
                if (loads && ALUop != 3'd6) mStatus = {v, res >= 32768, res == 0};
                if (loadc || (loads && ALUop != 3'd6)) begin
                    e = '{due: cyc, isMul: 1'b0, c: 16'(mC), st: mStatus};
                    expQ.push_back(e);
                end
            end
        end
        expBusy = mBusy;
        expDone = completed;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (expQ.size() > 0 && expQ[0].due < cyc) begin
                checkOutput("queue_due", expQ[0].due, cyc);
                void'(expQ.pop_front());
            end
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                e = expQ.pop_front();
                if (e.isMul) checkOutput("mul_done_pulse", done, 1);
                shadowC  = e.c;
                shadowSt = e.st;
            end
            checkOutput("C", C, shadowC);
            checkOutput("status", status, shadowSt);
            checkOutput("busy", busy, expBusy);
            checkOutput("done", done, expDone);
        end
    end

    task automatic clearInputs();
        reset = 0; readnum = '0; writenum = '0; write = 0; vsel = '0;
        mdata = '0; sximm8 = '0; sximm5 = '0; PC = '0; csel = 0;
        loada = 0; loadb = 0; loadc = 0; loads = 0; asel = 0; bsel = 0;
        shift = '0; ALUop = '0;
    endtask

    task automatic idle(int n);
        clearInputs();
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic writeReg(int r, int val);
        clearInputs();
        write = 1; writenum = RW'(r); vsel = 2'd2; sximm8 = 16'(val);
        applyStimulus();
        clearInputs();
    endtask

    task automatic loadOperand(bit toA, int val);
        clearInputs();
        csel = 1; vsel = 2'd2; sximm8 = 16'(val);
        if (toA) loada = 1; else loadb = 1;
        applyStimulus();
        clearInputs();
    endtask

    task automatic runAlu(int op, bit useLoads, bit aselV, bit bselV, int shiftV, int imm5);
        clearInputs();
        ALUop = 3'(op); loadc = 1; loads = useLoads; asel = aselV; bsel = bselV;
        shift = 2'(shiftV); sximm5 = 16'(imm5);
        applyStimulus();
        clearInputs();
    endtask

    task automatic waitMulDone();
        clearInputs();
        for (int i = 0; i < 3 * WIDTH && mBusy; i++) applyStimulus();
        checkOutput("mul_timeout", mBusy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        reset = 1;
        applyStimulus();
        applyStimulus();
        clearInputs();

        $display("[TB] basic add through register file");
        writeReg(0, 5);
        writeReg(1, 7);
        readnum = 3'd0; loada = 1; applyStimulus(); clearInputs();
        readnum = 3'd1; loadb = 1; applyStimulus(); clearInputs();
        runAlu(0, 1, 0, 0, 0, 0);
        idle(1);

        $display("[TB] overflow and zero flags");
        loadOperand(1, 16'h7FFF);
        loadOperand(0, 16'h0001);
        runAlu(0, 1, 0, 0, 0, 0);
        loadOperand(1, 3);
        loadOperand(0, 3);
        runAlu(1, 1, 0, 0, 0, 0);
        idle(1);

        $display("[TB] multiply with ignored mid-run loadc");
        loadOperand(1, 300);
        loadOperand(0, 200);
        runAlu(6, 1, 0, 0, 0, 0);
        idle(5);
        runAlu(0, 1, 0, 0, 0, 0);
        vsel = 2'd0; write = 1; writenum = 3'd4; applyStimulus(); clearInputs();
        waitMulDone();
        idle(2);

        $display("[TB] reset during multiply");
        writeReg(2, 16'h55);
        writeReg(7, 16'hA5A5);
        runAlu(6, 1, 0, 0, 0, 0);
        idle(4);
        reset = 1; applyStimulus(); clearInputs();
        idle(2);
        for (int r = 0; r < NREG; r++) begin
            readnum = RW'(r); loada = 1; applyStimulus(); clearInputs();
            runAlu(0, 0, 0, 1, 0, 0);
        end

        $display("[TB] shifter and PC write-back");
        loadOperand(0, 16'h8001);
        runAlu(0, 1, 1, 0, 3, 0);
        runAlu(0, 1, 1, 0, 2, 0);
        runAlu(0, 1, 1, 0, 1, 0);
        csel = 1; vsel = 2'd1; PC = 9'h1FF; loada = 1; applyStimulus(); clearInputs();
        runAlu(0, 1, 0, 1, 0, 0);

        $display("[TB] back-to-back multiplies");
        loadOperand(1, 16'hFFFF);
        loadOperand(0, 16'h0003);
        clearInputs();
        ALUop = 3'd6; loadc = 1; loads = 1;
        for (int i = 0; i < 2 * WIDTH + 3; i++) applyStimulus();
        waitMulDone();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            readnum  = RW'($urandom);
            writenum = RW'($urandom);
            write    = 1'($urandom);
            vsel     = 2'($urandom);
            mdata    = 16'($urandom);
            sximm8   = 16'($urandom);
            sximm5   = 16'($urandom);
            PC       = 9'($urandom);
            csel     = 1'($urandom);
            loada    = 1'($urandom);
            loadb    = 1'($urandom);
            loadc    = ($urandom_range(0, 2) == 0);
            loads    = loadc & 1'($urandom);
            asel     = ($urandom_range(0, 3) == 0);
            bsel     = ($urandom_range(0, 3) == 0);
            shift    = 2'($urandom);
            ALUop    = 3'($urandom);
            applyStimulus();
        end
        waitMulDone();
        idle(2);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the datapath, register file, pipeline register and operand width.
REQ-002 Parameter NREG, default 8, SHALL set the register count; RW = ceil(log2(NREG)) SHALL be the register index width.
REQ-003 Parameter PCW, default 9, SHALL set the PC input width; PCW <= WIDTH.
REQ-004 Ports SHALL be as follows:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- readnum, writenum  in  RW  register file read and write index.
- write  in  1  register file write enable.
- vsel  in  2  write-back source: 00 C, 01 zero-extended PC, 10 sximm8, 11 mdata.
- mdata, sximm8, sximm5  in  WIDTH  memory data and sign-extended immediates.
- PC  in  PCW  program counter.
- csel  in  1  A/B load source: 1 write-back value, 0 register file read data.
- loada, loadb, loadc, loads  in  1  enables for A, B, C and status.
- asel  in  1  1 forces ALU A operand to 0.
- bsel  in  1  1 selects sximm5 as ALU B operand.
- shift  in  2  B shifter: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
- ALUop  in  3  000 ADD, 001 SUB, 010 AND, 011 NOT B, 100 OR, 101 XOR, 110 MUL, 111 ADD.
- C  out  WIDTH  C register.
- status  out  3  {V,N,Z}.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse on multiply completion.

Function
REQ-005 The register file SHALL read data combinationally at readnum and write the write-back value at the clock edge when write=1.
- A same-cycle read SHALL return the old contents.
- An index >= NREG SHALL be ignored on write and SHALL read as 0.
REQ-006 A and B SHALL load the csel-selected value at the edge when their enable is 1, independent of busy.
REQ-007 Arithmetic SHALL be modulo 2^WIDTH.
- Z = (result == 0); N = result[WIDTH-1].
- V = signed overflow for ADD and SUB, else 0.
REQ-008 Single-cycle ops (all ALUop except 110): with loadc=1 and busy=0, C SHALL take the result at that edge.
- status SHALL update at the same edge iff loads=1.
- Latency: 1 cycle from the enables to C.
REQ-009 Multiply SHALL use state machine IDLE -> MUL -> IDLE.
- IDLE: busy=0. ALUop=110 with loadc=1 SHALL capture both operands and loads into internal registers and enter MUL.
- MUL: busy=1. One shift-add step per cycle for exactly WIDTH cycles.
- On the final step, C SHALL take the low WIDTH bits of the product, status SHALL update if the captured loads was 1 (V=0), done SHALL pulse at the next cycle, and the block SHALL return to IDLE.
- Latency: WIDTH+1 edges from capture to C updating.
REQ-010 While busy=1, loadc and loads SHALL be ignored; A, B, the register file and vsel=00 write-back SHALL still operate, with write-back showing the not-yet-updated C.
REQ-011 In IDLE, a single-cycle op and a MUL capture are mutually exclusive by ALUop; no queuing of rejected requests.
REQ-012 A multiply request at the same edge as done SHALL be accepted, since done is asserted in IDLE.
REQ-013 Shifter: left shift fills LSB 0; logical right fills 0; arithmetic right replicates the MSB.

Reset
REQ-014 While reset=1 at an edge:
- all NREG registers, A, B, C and the multiply internals SHALL clear to 0;
- status SHALL clear to 000; busy and done SHALL clear to 0; the state SHALL be IDLE.
REQ-015 Reset during MUL SHALL abort the multiply with no C or status update and no done pulse.
REQ-016 Reset SHALL take priority over write, loada, loadb, loadc and loads.

Verification
REQ-017 Load R0=5 (vsel=10, sximm8=5), R1=7; A<-R0, B<-R1; ADD, loadc, loads -> C=12, status=000.
REQ-018 A=0x7FFF, B=0x0001, ADD with loads -> C=0x8000, status=110 (V=1, N=1, Z=0); SUB A=B=3 -> C=0, status=001.
REQ-019 A=300, B=200, MUL with loads -> busy high 16 cycles, C=0xEA60, done pulses once, status=010; loadc pulsed mid-multiply is ignored.
REQ-020 Start MUL, assert reset on cycle 5 -> busy=0, C=0, status=000, no done pulse; all registers read 0.
REQ-021 B=0x8001 with shift=11 and shift=10 -> ADD with asel=1 gives C=0xC000 and C=0x4000; csel=1 with vsel=01, PC=0x1FF loads A=0x01FF.
